// File: rtl/uart_tx_cfg_if.sv
// rtl/uart_tx_cfg_if.sv - handshake, config and serial line bundle of the UART transmitter
interface uart_tx_cfg_if #(
  parameter int D_BIT = 8
);
  logic             i_s_tick;
  logic             i_tx_start;
  logic [D_BIT-1:0] i_data;
  logic [1:0]       i_parity_mode;
  logic             i_two_stop;
  logic             o_tx_ready;
  logic             o_busy;
  logic             o_tx_done_tick;
  logic             o_tx;

  modport master (
    output i_s_tick, i_tx_start, i_data, i_parity_mode, i_two_stop,
    input  o_tx_ready, o_busy, o_tx_done_tick, o_tx
  );

  modport slave (
    input  i_s_tick, i_tx_start, i_data, i_parity_mode, i_two_stop,
    output o_tx_ready, o_busy, o_tx_done_tick, o_tx
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - buffered UART transmitter with configurable parity and stop bits
module uart_tx_cfg #(
  parameter int D_BIT      = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  uart_tx_cfg_if.slave bus
);
  localparam int TW = $clog2(2 * OVERSAMPLE);
  localparam int BW = $clog2(D_BIT);
  localparam logic [TW-1:0] ONE_BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TWO_BIT_LAST  = TW'(2 * OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA_BIT = BW'(D_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [D_BIT-1:0] shift_q, shift_d;
  logic             pen_q, pen_d;
  logic             par_q, par_d;
  logic             two_q, two_d;
  logic             hold_full_q, hold_full_d;
  logic [D_BIT-1:0] hold_data_q, hold_data_d;
  logic [1:0]       hold_mode_q, hold_mode_d;
  logic             hold_two_q, hold_two_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;

  logic             accept;
  logic             load;
  logic             bit_end;
  logic [TW-1:0]    tick_last;

  assign accept    = bus.i_tx_start && !hold_full_q;
  assign tick_last = (state_q == S_STOP && two_q) ? TWO_BIT_LAST : ONE_BIT_LAST;
  assign bit_end   = bus.i_s_tick && (tick_q == tick_last);

  // Next-state, counters, holding register and next line level
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    pen_d       = pen_q;
    par_d       = par_q;
    two_d       = two_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    hold_mode_d = hold_mode_q;
    hold_two_d  = hold_two_q;
    done_d      = 1'b0;
    load        = 1'b0;
    tx_d        = 1'b1;

    if (state_q != S_IDLE && bus.i_s_tick) begin
      tick_d = bit_end ? '0 : tick_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (hold_full_q) load = 1'b1;
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_DATA_BIT) begin
            bit_d   = '0;
            state_d = pen_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          done_d = 1'b1;
          if (hold_full_q) load = 1'b1;
          else             state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Frame config is taken from the holding register, never from live inputs
    if (load) begin
      state_d     = S_START;
      tick_d      = '0;
      bit_d       = '0;
      shift_d     = hold_data_q;
      pen_d       = ^hold_mode_q;
      par_d       = (^hold_data_q) ^ (hold_mode_q == 2'b10);
      two_d       = hold_two_q;
      hold_full_d = 1'b0;
    end

    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = bus.i_data;
      hold_mode_d = bus.i_parity_mode;
      hold_two_d  = bus.i_two_stop;
    end

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      pen_q       <= 1'b0;
      par_q       <= 1'b0;
      two_q       <= 1'b0;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      hold_mode_q <= '0;
      hold_two_q  <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      pen_q       <= pen_d;
      par_q       <= par_d;
      two_q       <= two_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      hold_mode_q <= hold_mode_d;
      hold_two_q  <= hold_two_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
    end
  end

  assign bus.o_tx           = tx_q;
  assign bus.o_tx_ready     = !hold_full_q;
  assign bus.o_busy         = (state_q != S_IDLE);
  assign bus.o_tx_done_tick = done_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - self-checking bench for uart_tx_cfg
module tb_uart_tx_cfg;
  localparam int D_BIT = 8;
  localparam int OS    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_en = 1'b1;
  int   tick_div = 0;
  int   checks = 0;
  int   failures = 0;

  initial forever #5 clk = ~clk;

  uart_tx_cfg_if #(.D_BIT(D_BIT)) bus ();

  uart_tx_cfg #(.D_BIT(D_BIT), .OVERSAMPLE(OS)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct packed {
    logic [7:0]  data;
    logic [1:0]  pm;
    logic        two;
    logic        par;
    logic [15:0] ticks;
  } vec_t;

  vec_t vecs [6];

  logic rec [$];
  logic exp_q [$];
  int   done_pos [$];
  logic done_tx [$];
  logic done_busy [$];
  logic done_rdy [$];
  logic done_prev_rdy [$];
  logic prev_rdy = 1'b1;

  // Baud tick: one cycle in four, changed away from the sampling edge
  initial begin
    bus.i_s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (tick_en) begin
        tick_div = (tick_div + 1) % 4;
        bus.i_s_tick = (tick_div == 0);
      end else begin
        bus.i_s_tick = 1'b0;
      end
    end
  end

  // Line monitor: one sample per consumed tick, plus a snapshot at every done pulse
  initial forever begin
    @(negedge clk);
    if (bus.o_busy && bus.i_s_tick) rec.push_back(bus.o_tx);
    if (bus.o_tx_done_tick) begin
      done_pos.push_back(rec.size());
      done_tx.push_back(bus.o_tx);
      done_busy.push_back(bus.o_busy);
      done_rdy.push_back(bus.o_tx_ready);
      done_prev_rdy.push_back(prev_rdy);
    end
    prev_rdy = bus.o_tx_ready;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear();
    rec.delete();
    exp_q.delete();
    done_pos.delete();
    done_tx.delete();
    done_busy.delete();
    done_rdy.delete();
    done_prev_rdy.delete();
  endtask

  task automatic add_frame(input logic [7:0] d, input logic [1:0] pm, input logic par, input logic two);
    repeat (OS) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (OS) exp_q.push_back(d[i]);
    if (pm == 2'b01 || pm == 2'b10) repeat (OS) exp_q.push_back(par);
    repeat (two ? 2 * OS : OS) exp_q.push_back(1'b1);
  endtask

  task automatic compare_rec(input string name);
    check({name, " len"}, rec.size(), exp_q.size());
    for (int g = 0; g < exp_q.size() / OS; g++) begin
      int good;
      good = 0;
      for (int k = 0; k < OS; k++) begin
        int idx;
        idx = g * OS + k;
        if (idx < rec.size() && rec[idx] === exp_q[idx]) good++;
      end
      check($sformatf("%s bit%0d samples", name, g), good, OS);
    end
  endtask

  // Write from idle; chk enables the write-to-start latency checks
  task automatic write(input logic [7:0] d, input logic [1:0] pm, input logic two, input logic chk);
    @(negedge clk);
    bus.i_data = d;
    bus.i_parity_mode = pm;
    bus.i_two_stop = two;
    bus.i_tx_start = 1'b1;
    @(posedge clk);
    #1;
    if (chk) check("ready after E0", bus.o_tx_ready, 1'b0);
    @(negedge clk);
    bus.i_tx_start = 1'b0;
    bus.i_data = ~d;
    bus.i_parity_mode = ~pm;
    bus.i_two_stop = ~two;
    @(posedge clk);
    #1;
    if (chk) begin
      check("tx after E1", bus.o_tx, 1'b0);
      check("busy after E1", bus.o_busy, 1'b1);
      check("ready after E1", bus.o_tx_ready, 1'b1);
    end
  endtask

  task automatic wait_done(input int n, input int budget);
    int c;
    c = 0;
    while (done_pos.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    check("done pulses reached", done_pos.size(), n);
  endtask

  task automatic wait_rec(input int n, input int budget);
    int c;
    c = 0;
    while (rec.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    check("tick samples reached", rec.size() >= n, 1'b1);
  endtask

  initial begin
    int changes;
    logic lvl;

    bus.i_tx_start = 1'b0;
    bus.i_data = '0;
    bus.i_parity_mode = 2'b00;
    bus.i_two_stop = 1'b0;

    vecs[0] = '{data: 8'hA5, pm: 2'b00, two: 1'b0, par: 1'b0, ticks: 16'd160};
    vecs[1] = '{data: 8'h03, pm: 2'b10, two: 1'b0, par: 1'b1, ticks: 16'd176};
    vecs[2] = '{data: 8'h03, pm: 2'b01, two: 1'b0, par: 1'b0, ticks: 16'd176};
    vecs[3] = '{data: 8'h07, pm: 2'b01, two: 1'b0, par: 1'b1, ticks: 16'd176};
    vecs[4] = '{data: 8'hA5, pm: 2'b00, two: 1'b1, par: 1'b0, ticks: 16'd176};
    vecs[5] = '{data: 8'h3C, pm: 2'b11, two: 1'b0, par: 1'b0, ticks: 16'd160};

    repeat (3) @(negedge clk);
    check("reset tx", bus.o_tx, 1'b1);
    check("reset ready", bus.o_tx_ready, 1'b1);
    check("reset busy", bus.o_busy, 1'b0);
    check("reset done", bus.o_tx_done_tick, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle tx", bus.o_tx, 1'b1);

    for (int v = 0; v < 6; v++) begin
      clear();
      add_frame(vecs[v].data, vecs[v].pm, vecs[v].par, vecs[v].two);
      write(vecs[v].data, vecs[v].pm, vecs[v].two, 1'b1);
      wait_done(1, 2000);
      compare_rec($sformatf("vec%0d", v));
      check($sformatf("vec%0d done position", v), done_pos[0], vecs[v].ticks);
      check($sformatf("vec%0d busy at done", v), done_busy[0], 1'b0);
      repeat (20) @(posedge clk);
      check($sformatf("vec%0d single done", v), done_pos.size(), 1);
    end

    // Back-to-back: queue 0x55 during 0x0F's data phase, then a write that must be ignored
    clear();
    add_frame(8'h0F, 2'b00, 1'b0, 1'b0);
    add_frame(8'h55, 2'b00, 1'b0, 1'b0);
    write(8'h0F, 2'b00, 1'b0, 1'b0);
    wait_rec(48, 2000);
    @(negedge clk);
    bus.i_data = 8'h55;
    bus.i_parity_mode = 2'b00;
    bus.i_two_stop = 1'b0;
    bus.i_tx_start = 1'b1;
    @(posedge clk);
    #1;
    check("queue ready low", bus.o_tx_ready, 1'b0);
    @(negedge clk);
    bus.i_data = 8'hFF;
    bus.i_parity_mode = 2'b01;
    @(negedge clk);
    bus.i_tx_start = 1'b0;
    wait_done(2, 3000);
    compare_rec("b2b");
    check("b2b done0 position", done_pos[0], 160);
    check("b2b done1 position", done_pos[1], 320);
    check("b2b start at done", done_tx[0], 1'b0);
    check("b2b busy at done", done_busy[0], 1'b1);
    check("b2b ready at load", done_rdy[0], 1'b1);
    check("b2b ready before load", done_prev_rdy[0], 1'b0);
    repeat (100) @(posedge clk);
    check("b2b third write ignored", bus.o_busy, 1'b0);
    check("b2b done count", done_pos.size(), 2);

    // Tick stall in the middle of data bit 1 of 0x35 (bit1 = 0)
    clear();
    add_frame(8'h35, 2'b00, 1'b0, 1'b0);
    write(8'h35, 2'b00, 1'b0, 1'b1);
    wait_rec(37, 2000);
    @(negedge clk);
    tick_en = 1'b0;
    lvl = bus.o_tx;
    changes = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.o_tx !== lvl) changes++;
    end
    check("stall level", lvl, 1'b0);
    check("stall changes", changes, 0);
    tick_en = 1'b1;
    wait_done(1, 2000);
    compare_rec("stall");

    // Reset during the parity bit of 0x07 odd (parity 0), with 0x11 held
    clear();
    write(8'h07, 2'b10, 1'b0, 1'b1);
    wait_rec(16 * 9 + 4, 2000);
    @(negedge clk);
    bus.i_data = 8'h11;
    bus.i_parity_mode = 2'b00;
    bus.i_tx_start = 1'b1;
    @(negedge clk);
    bus.i_tx_start = 1'b0;
    check("parity level before reset", bus.o_tx, 1'b0);
    check("held before reset", bus.o_tx_ready, 1'b0);
    rst = 1'b1;
    #1;
    check("mid reset tx", bus.o_tx, 1'b1);
    check("mid reset ready", bus.o_tx_ready, 1'b1);
    check("mid reset busy", bus.o_busy, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(posedge clk);
    check("no done after reset", done_pos.size(), 0);
    check("held data discarded", bus.o_busy, 1'b0);
    clear();
    add_frame(8'hA5, 2'b00, 1'b0, 1'b0);
    write(8'hA5, 2'b00, 1'b0, 1'b1);
    wait_done(1, 2000);
    compare_rec("post reset");
    check("post reset done position", done_pos[0], 160);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised, buffered UART transmitter for the serial I/O path. It serialises one character per frame: start bit, 5–9 data bits LSB first, optional even/odd parity, and one or two stop bits, each bit held for a configurable number of baud ticks. A one-entry holding register allows the next character to be queued during transmission, giving gap-free back-to-back frames. It is driven by the shared baud-rate tick generator and feeds the top-level tx pin.

## Interface
- D_BIT, default 8: data bits per frame; legal range 5..9.
- OVERSAMPLE, default 16: baud ticks per bit; legal range 4..64.
- i_clk  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_s_tick  in  1  baud tick strobe; one i_clk cycle wide.
- i_tx_start  in  1  write strobe; accepted only while o_tx_ready=1.
- i_data  in  D_BIT  character to send; captured on an accepted write.
- i_parity_mode  in  2  00 none, 01 even, 10 odd, 11 none.
- i_two_stop  in  1  0 = one stop bit, 1 = two stop bits.
- o_tx_ready  out  1  holding register is empty.
- o_busy  out  1  state is not IDLE.
- o_tx_done_tick  out  1  one-cycle pulse at the end of each frame.
- o_tx  out  1  serial line, registered, idle high.

## Operation
- Reset values: o_tx=1, o_tx_ready=1, o_busy=0, o_tx_done_tick=0. Holding register empty, state IDLE, counters 0.
- Write accept: i_tx_start && o_tx_ready captures i_data, i_parity_mode and i_two_stop into the holding register. The register is full after that edge.
- i_tx_start while o_tx_ready=0: ignored; the held data is not overwritten.
- States are IDLE, START, DATA, PARITY, STOP.
- IDLE: line is 1. When the holding register is full, move to START on the next edge. On that edge, load the shift register and frame config from the holding register, and empty the holding register.
- START: line is 0 for OVERSAMPLE ticks, then move to DATA.
- DATA: line is shift_reg[0], held for OVERSAMPLE ticks. After each bit, shift right. After D_BIT bits:
  - go to PARITY if the frame mode is 01 or 10;
  - otherwise go to STOP.
- PARITY: line is the XOR of the D_BIT data bits (even mode) or its inverse (odd mode), held for OVERSAMPLE ticks.
- STOP: line is 1 for OVERSAMPLE ticks (one stop bit) or 2×OVERSAMPLE ticks (two stop bits). On the edge that consumes the final tick:
  - pulse o_tx_done_tick;
  - go to START if the holding register is full (back-to-back, reloading as in IDLE);
  - otherwise go to IDLE.
- Counters:
  - Tick counter is $clog2(2×OVERSAMPLE) bits wide. It advances only when i_s_tick=1 and clears at every bit boundary.
  - Bit counter is $clog2(D_BIT) bits wide and wraps to 0 when leaving DATA.
- Mode inputs are sampled only at write accept. Changing them mid-frame has no effect on the frame in flight.

## Timing
- o_tx is registered and loaded with the next-state line value, so it changes on the same edge as the state.
- Write at edge E0 in IDLE:
  - o_tx_ready=0 after E0;
  - state=START and o_tx=0 after E1;
  - o_tx_ready=1 again after E1.
- Bit duration is exactly OVERSAMPLE i_s_tick pulses, independent of tick spacing. With no ticks, the line holds its level indefinitely.
- Frame length in ticks: OVERSAMPLE × (1 + D_BIT + P + S), where P is 0 or 1 (parity) and S is 1 or 2 (stop bits).
- Back-to-back: the next start bit begins on the edge after the final stop tick, with no idle clock cycles in between.
- A write on the same edge the holding register is emptied is not possible, because o_tx_ready is 0 on that edge.
- i_reset asserted mid-frame: all outputs return to reset values immediately (asynchronous). The frame and any held data are discarded, and no done pulse is produced.

## Test plan
- 8N1 send of 0xA5, tick every 4 clocks, OVERSAMPLE=16:
  - line is 0, 1,0,1,0,0,1,0,1, 1, with each bit 16 ticks (64 clocks);
  - one o_tx_done_tick at frame end;
  - then o_busy=0.
- Odd parity, 0x03: parity bit =1. Even parity, 0x03: parity bit =0. Even parity, 0x07: parity bit =1.
- Two stop bits: the stop high time is 32 ticks, and o_tx_done_tick comes 16 ticks later than in the 1-stop case.
- Queue 0x55 during 0x0F's data phase:
  - o_tx_ready drops, then rises on the edge 0x55 is loaded;
  - 0x55's start bit follows 0x0F's last stop tick with no gap;
  - a third write while o_tx_ready=0 is ignored.
- Stall i_s_tick for 100 clocks mid-data: the bit level is held and the bit is not shortened.
- Assert i_reset during the parity bit:
  - o_tx=1, o_tx_ready=1, o_busy=0 immediately;
  - no done pulse;
  - the next write starts a clean frame.
